// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: reset vector, NOP, fetch FSM encoding,
// IF/ID bundle, ALU-op and branch-type constants.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;
  localparam logic [31:0] NOP      = 32'h0340_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  localparam logic [3:0] BR_EQ   = 4'b0000;
  localparam logic [3:0] BR_NE   = 4'b0001;
  localparam logic [3:0] BR_LT   = 4'b0010;
  localparam logic [3:0] BR_GE   = 4'b0011;
  localparam logic [3:0] BR_JMP  = 4'b0100;
  localparam logic [3:0] BR_NONE = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle.
// At most one request is outstanding at a time.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: redirect/flush bubble,
// then stall hold, then load, else bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   flush,
  input  logic   br_taken,
  input  logic   stall,
  input  if_id_t din,
  output if_id_t dout
);

  localparam if_id_t BUBBLE = '{
    valid: 1'b0, pc: 32'h0, inst: NOP
  };

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout <= BUBBLE;
    end else begin
      priority case (1'b1)
        (flush | br_taken): dout <= BUBBLE;
        stall:              dout <= dout;
        din.valid:          dout <= din;
        default:            dout <= BUBBLE;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem FSM with
// one-entry hold buffer feeding the IF/ID register.
module fetch_stage (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master imem,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          stall,
  input  logic          flush,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst
);
  import fetch_stage_pkg::*;

  fetch_state_e state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic         hbuf_valid, hbuf_valid_nx;
  logic [31:0]  hbuf_inst, hbuf_inst_nx;
  logic [31:0]  hbuf_pc, hbuf_pc_nx;
  if_id_t       fetched;
  if_id_t       id_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      hbuf_valid <= 1'b0;
      hbuf_inst  <= NOP;
      hbuf_pc    <= RESET_PC;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      hbuf_valid <= hbuf_valid_nx;
      hbuf_inst  <= hbuf_inst_nx;
      hbuf_pc    <= hbuf_pc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    hbuf_valid_nx = hbuf_valid;
    hbuf_inst_nx  = hbuf_inst;
    hbuf_pc_nx    = hbuf_pc;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (br_taken) pc_nx = br_target;
        if (imem.imem_ready)
          state_nx = br_taken ? KILL : WAIT;
      end
      WAIT: begin
        if (hbuf_valid) begin
          if (br_taken) begin
            hbuf_valid_nx = 1'b0;
            pc_nx         = br_target;
            state_nx      = REQ;
          end else if (!stall) begin
            hbuf_valid_nx = 1'b0;
            pc_nx         = pc + PC_STEP;
            state_nx      = REQ;
          end
        end else if (imem.imem_rvalid) begin
          if (br_taken) begin
            pc_nx    = br_target;
            state_nx = REQ;
          end else if (stall) begin
            hbuf_valid_nx = 1'b1;
            hbuf_inst_nx  = imem.imem_rdata;
            hbuf_pc_nx    = pc;
          end else begin
            pc_nx    = pc + PC_STEP;
            state_nx = REQ;
          end
        end else if (br_taken) begin
          // response still in flight: drop it in KILL
          pc_nx    = br_target;
          state_nx = KILL;
        end
      end
      KILL: begin
        if (br_taken) pc_nx = br_target;
        if (imem.imem_rvalid) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == REQ);
    imem.imem_addr = pc;
    fetched        = '{valid: 1'b0, pc: pc, inst: NOP};
    if (state == WAIT && !br_taken && !stall) begin
      if (hbuf_valid)
        fetched = '{valid: 1'b1, pc: hbuf_pc,
                    inst: hbuf_inst};
      else if (imem.imem_rvalid)
        fetched = '{valid: 1'b1, pc: pc,
                    inst: imem.imem_rdata};
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .br_taken (br_taken),
    .stall    (stall),
    .din      (fetched),
    .dout     (id_q)
  );

  assign id_valid = id_q.valid;
  assign id_pc    = id_q.pc;
  assign id_inst  = id_q.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming,
// stall hold, redirects, flush, pc wrap, reset mid-fetch.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1C00_0000;
  localparam logic [31:0] NOPW = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  int          errors = 0;
  int          checks = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk       (clk),
    .rstn      (rstn),
    .imem      (imem.master),
    .br_taken  (br_taken),
    .br_target (br_target),
    .stall     (stall),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_one(input logic [31:0] data);
    imem.imem_ready = 1'b1;
    step();
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = data;
    step();
    imem.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    br_taken = 1'b0; br_target = '0;
    stall = 1'b0; flush = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    @(negedge clk);
    checks++; if (imem.imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %h want 0", imem.imem_req); end
    checks++; if (imem.imem_addr !== RPC) begin errors++;
      $display("FAIL rst_addr: got %h want %h", imem.imem_addr, RPC); end
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %h want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++;
      $display("FAIL rst_pc: got %h want 0", id_pc); end
    checks++; if (id_inst !== NOPW) begin errors++;
      $display("FAIL rst_inst: got %h want %h", id_inst, NOPW); end
    rstn = 1'b1;
    step();
    checks++; if (imem.imem_req !== 1'b1) begin errors++;
      $display("FAIL first_req: got %h want 1", imem.imem_req); end
    checks++; if (imem.imem_addr !== RPC) begin errors++;
      $display("FAIL first_addr: got %h want %h", imem.imem_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) begin
      ea = RPC + 32'(4 * i);
      ed = 32'h0010_0093 + 32'(i);
      checks++; if (imem.imem_addr !== ea) begin errors++;
        $display("FAIL seq_addr%0d: got %h want %h", i, imem.imem_addr, ea); end
      imem.imem_ready = 1'b1;
      step();
      checks++; if (id_valid !== 1'b0 || imem.imem_req !== 1'b0) begin errors++;
        $display("FAIL seq_gap%0d: got v=%h req=%h want 0 0", i, id_valid, imem.imem_req); end
      imem.imem_ready = 1'b0;
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata = ed;
      step();
      imem.imem_rvalid = 1'b0;
      checks++; if (id_valid !== 1'b1 || id_pc !== ea || id_inst !== ed) begin errors++;
        $display("FAIL seq_id%0d: got %h %h %h want 1 %h %h", i, id_valid, id_pc, id_inst, ea, ed); end
    end
  endtask

  task automatic test_stall_hold();
    imem.imem_ready = 1'b1;
    stall = 1'b1;
    step();
    imem.imem_ready = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== RPC + 32'hC) begin errors++;
      $display("FAIL stall_hold1: got %h %h want 1 %h", id_valid, id_pc, RPC + 32'hC); end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h0280_0421;
    step();
    imem.imem_rvalid = 1'b0;
    checks++; if (id_inst !== 32'h0010_0096 || imem.imem_req !== 1'b0) begin errors++;
      $display("FAIL stall_hold2: got %h req=%h want 00100096 0", id_inst, imem.imem_req); end
    step();
    checks++; if (id_pc !== RPC + 32'hC || imem.imem_req !== 1'b0) begin errors++;
      $display("FAIL stall_hold3: got %h req=%h want %h 0", id_pc, imem.imem_req, RPC + 32'hC); end
    stall = 1'b0;
    step();
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h0280_0421) begin errors++;
      $display("FAIL stall_release: got %h %h want 1 02800421", id_valid, id_inst); end
    checks++; if (id_pc !== RPC + 32'h10) begin errors++;
      $display("FAIL stall_pc: got %h want %h", id_pc, RPC + 32'h10); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RPC + 32'h14) begin errors++;
      $display("FAIL stall_next: got %h %h want 1 %h", imem.imem_req, imem.imem_addr, RPC + 32'h14); end
  endtask

  task automatic test_branch_wait();
    imem.imem_ready = 1'b1;
    step();
    imem.imem_ready = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h1C00_0100;
    step();
    br_taken = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem.imem_req !== 1'b0) begin errors++;
      $display("FAIL brw_kill: got v=%h req=%h want 0 0", id_valid, imem.imem_req); end
    step();
    checks++; if (id_valid !== 1'b0 || imem.imem_req !== 1'b0) begin errors++;
      $display("FAIL brw_idle: got v=%h req=%h want 0 0", id_valid, imem.imem_req); end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== NOPW) begin errors++;
      $display("FAIL brw_drop: got %h %h want 0 %h", id_valid, id_inst, NOPW); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h1C00_0100) begin errors++;
      $display("FAIL brw_addr: got %h %h want 1 1c000100", imem.imem_req, imem.imem_addr); end
    fetch_one(32'h0000_0013);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1C00_0100) begin errors++;
      $display("FAIL brw_target: got %h %h want 1 1c000100", id_valid, id_pc); end
  endtask

  task automatic test_branch_accept();
    imem.imem_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h1C00_0200;
    step();
    imem.imem_ready = 1'b0;
    br_taken = 1'b0;
    checks++; if (imem.imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++;
      $display("FAIL bra_kill: got req=%h v=%h want 0 0", imem.imem_req, id_valid); end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hBAD0_BAD0;
    step();
    imem.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== NOPW) begin errors++;
      $display("FAIL bra_drop: got %h %h want 0 %h", id_valid, id_inst, NOPW); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h1C00_0200) begin errors++;
      $display("FAIL bra_addr: got %h %h want 1 1c000200", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_flush_stall();
    fetch_one(32'h0000_0033);
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h0000_0033) begin errors++;
      $display("FAIL fs_pre: got %h %h want 1 00000033", id_valid, id_inst); end
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== NOPW) begin errors++;
      $display("FAIL fs_bubble: got %h %h want 0 %h", id_valid, id_inst, NOPW); end
    checks++; if (imem.imem_addr !== 32'h1C00_0204) begin errors++;
      $display("FAIL fs_addr: got %h want 1c000204", imem.imem_addr); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_redir: got %h %h want 1 fffffffc", imem.imem_req, imem.imem_addr); end
    fetch_one(32'h1234_5678);
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h1234_5678) begin errors++;
      $display("FAIL wrap_id: got %h %h want fffffffc 12345678", id_pc, id_inst); end
    checks++; if (imem.imem_addr !== 32'h0) begin errors++;
      $display("FAIL wrap_addr: got %h want 00000000", imem.imem_addr); end
    br_taken = 1'b1;
    br_target = 32'h1C00_0302;
    step();
    br_taken = 1'b0;
    checks++; if (imem.imem_addr !== 32'h1C00_0302) begin errors++;
      $display("FAIL misalign: got %h want 1c000302", imem.imem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    imem.imem_ready = 1'b1;
    step();
    imem.imem_ready = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== RPC) begin errors++;
      $display("FAIL rmw_async: got %h %h want 0 %h", imem.imem_req, imem.imem_addr, RPC); end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hCAFE_F00D;
    step();
    rstn = 1'b1;
    step();
    imem.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== NOPW) begin errors++;
      $display("FAIL rmw_ignore: got %h %h want 0 %h", id_valid, id_inst, NOPW); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RPC) begin errors++;
      $display("FAIL rmw_restart: got %h %h want 1 %h", imem.imem_req, imem.imem_addr, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_wait();
    test_branch_accept();
    test_flush_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
